// File: rtl/uart_pkg.sv
// Shared constants and FSM state encodings for the 8N1 DDS-timed UART.
package uart_pkg;
    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 8;
    localparam int DATA_BITS  = 8;

    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] TICK_MID  = 4'(MID_TICK - 1);
    localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_dds_transceiver_if.sv
// Byte-level host handshake of the UART; UART_RX_FRAME_ERR_EN adds rx_frame_err.
interface uart_dds_transceiver_if;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_done;
    logic [7:0] rx_data;
    logic       rx_done;
`ifdef UART_RX_FRAME_ERR_EN
    logic       rx_frame_err;

    modport master (output tx_data, tx_wr, input tx_done, rx_data, rx_done, rx_frame_err);
    modport slave  (input tx_data, tx_wr, output tx_done, rx_data, rx_done, rx_frame_err);
`else
    modport master (output tx_data, tx_wr, input tx_done, rx_data, rx_done);
    modport slave  (input tx_data, tx_wr, output tx_done, rx_data, rx_done);
`endif
endinterface

// File: rtl/uart_baud_dds.sv
// Fractional DDS: adds baudrate*1600 per clock modulo CLK_FREQ, strobing enable_16 on each wrap.
module uart_baud_dds #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BAUD_W-1:0] baudrate,
    output logic              enable_16
);
    localparam int ACC_W = $clog2(2 * CLK_FREQ);
    localparam logic [ACC_W:0] MODULUS = (ACC_W + 1)'(CLK_FREQ);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;
    logic [ACC_W:0]   acc_next;

    // One guard bit on the sum keeps the compare exact over the whole legal range.
    assign inc      = ACC_W'(baudrate) * ACC_W'(1600);
    assign acc_next = {1'b0, acc} + {1'b0, inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            enable_16 <= 1'b0;
        end else if (acc_next >= MODULUS) begin
            acc       <= ACC_W'(acc_next - MODULUS);
            enable_16 <= 1'b1;
        end else begin
            acc       <= acc_next[ACC_W-1:0];
            enable_16 <= 1'b0;
        end
    end
endmodule

// File: rtl/uart_dds_transceiver.sv
// 8N1 full-duplex UART timed by a 16x DDS strobe.
// Optional macro UART_RX_FRAME_ERR_EN exposes a stop-bit framing-error pulse.
module uart_dds_transceiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BAUD_W-1:0] baudrate,
    output logic              enable_16,
    input  logic              uart_rx,
    output logic              uart_tx,
    uart_dds_transceiver_if.slave host
);
    uart_baud_dds #(.CLK_FREQ(CLK_FREQ), .BAUD_W(BAUD_W)) u_dds (
        .clk(clk), .rst_n(rst_n), .baudrate(baudrate), .enable_16(enable_16)
    );

    tx_state_t  tx_state, tx_nxt;
    logic [3:0] tx_tick, tx_tick_n;
    logic [2:0] tx_bit, tx_bit_n;
    logic [7:0] tx_sh, tx_sh_n;
    logic       tx_line, tx_line_n, tx_done_q, tx_done_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE; tx_tick <= '0; tx_bit <= '0; tx_sh <= '0;
            tx_line <= 1'b1; tx_done_q <= 1'b0;
        end else begin
            tx_state <= tx_nxt; tx_tick <= tx_tick_n; tx_bit <= tx_bit_n; tx_sh <= tx_sh_n;
            tx_line <= tx_line_n; tx_done_q <= tx_done_n;
        end
    end

    // tx_done is registered, so the FSM is already IDLE when a back-to-back tx_wr arrives.
    always_comb begin
        tx_nxt = tx_state; tx_tick_n = tx_tick; tx_bit_n = tx_bit; tx_sh_n = tx_sh;
        tx_line_n = tx_line; tx_done_n = 1'b0;
        if (tx_state == TX_IDLE) begin
            tx_line_n = 1'b1;
            if (host.tx_wr) begin
                tx_sh_n = host.tx_data; tx_tick_n = '0; tx_bit_n = '0;
                tx_line_n = 1'b0; tx_nxt = TX_START;
            end
        end else if (enable_16) begin
            tx_tick_n = tx_tick + 4'd1;
            if (tx_tick == TICK_LAST) begin
                case (tx_state)
                    TX_START: begin tx_nxt = TX_DATA; tx_bit_n = '0; tx_line_n = tx_sh[0]; end
                    TX_DATA: begin
                        if (tx_bit == BIT_LAST) begin
                            tx_nxt = TX_STOP; tx_line_n = 1'b1;
                        end else begin
                            tx_bit_n = tx_bit + 3'd1; tx_sh_n = tx_sh >> 1; tx_line_n = tx_sh[1];
                        end
                    end
                    default: begin tx_nxt = TX_IDLE; tx_done_n = 1'b1; tx_line_n = 1'b1; end
                endcase
            end
        end
    end

    assign uart_tx      = tx_line;
    assign host.tx_done = tx_done_q;

    rx_state_t  rx_state, rx_nxt;
    logic [1:0] rx_sync;
    logic       rx_prev, rx_s;
    logic [3:0] rx_tick, rx_tick_n;
    logic [2:0] rx_bit, rx_bit_n;
    logic [7:0] rx_sh, rx_sh_n, rx_data_q, rx_data_n;
    logic       rx_done_q, rx_done_n;
`ifdef UART_RX_FRAME_ERR_EN
    logic       rx_ferr_q, rx_ferr_n;
`endif

    assign rx_s = rx_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync <= 2'b11; rx_prev <= 1'b1; rx_state <= RX_IDLE; rx_tick <= '0;
            rx_bit <= '0; rx_sh <= '0; rx_data_q <= '0; rx_done_q <= 1'b0;
        end else begin
            rx_sync <= {rx_sync[0], uart_rx}; rx_prev <= rx_s; rx_state <= rx_nxt;
            rx_tick <= rx_tick_n; rx_bit <= rx_bit_n; rx_sh <= rx_sh_n;
            rx_data_q <= rx_data_n; rx_done_q <= rx_done_n;
        end
    end

`ifdef UART_RX_FRAME_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_ferr_q <= 1'b0;
        else        rx_ferr_q <= rx_ferr_n;
    end
    assign host.rx_frame_err = rx_ferr_q;
`endif

    // Tick count restarts at mid start bit, so each later wrap lands mid-bit.
    always_comb begin
        rx_nxt = rx_state; rx_tick_n = rx_tick; rx_bit_n = rx_bit; rx_sh_n = rx_sh;
        rx_data_n = rx_data_q; rx_done_n = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
        rx_ferr_n = 1'b0;
`endif
        if (rx_state == RX_IDLE) begin
            if (rx_prev && !rx_s) begin
                rx_nxt = RX_START; rx_tick_n = '0; rx_bit_n = '0;
            end
        end else if (enable_16) begin
            rx_tick_n = rx_tick + 4'd1;
            case (rx_state)
                RX_START: if (rx_tick == TICK_MID) begin
                    rx_tick_n = '0;
                    rx_nxt = rx_s ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (rx_tick == TICK_LAST) begin
                    rx_sh_n = {rx_s, rx_sh[7:1]};
                    if (rx_bit == BIT_LAST) rx_nxt = RX_STOP;
                    else                    rx_bit_n = rx_bit + 3'd1;
                end
                default: if (rx_tick == TICK_LAST) begin
                    rx_nxt = RX_IDLE;
                    if (rx_s) begin
                        rx_data_n = rx_sh; rx_done_n = 1'b1;
                    end
`ifdef UART_RX_FRAME_ERR_EN
                    else rx_ferr_n = 1'b1;
`endif
                end
            endcase
        end
    end

    assign host.rx_data = rx_data_q;
    assign host.rx_done = rx_done_q;
endmodule

// File: tb/tb_uart_dds_transceiver.sv
// Directed bench for uart_dds_transceiver at 50 MHz / 1 Mbaud (50 clocks per bit).
`timescale 1ns/1ps
module tb_uart_dds_transceiver;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] baudrate;
    logic        enable_16, uart_rx, uart_tx;
    logic        loop, drv;
    int          n_chk = 0, n_pass = 0, cyc_now = 0, ferr_cnt = 0;
    logic [7:0]  rxq[$];

    uart_dds_transceiver_if host();

    assign uart_rx = loop ? uart_tx : drv;

    uart_dds_transceiver #(.CLK_FREQ(50000000), .BAUD_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .baudrate(baudrate), .enable_16(enable_16),
        .uart_rx(uart_rx), .uart_tx(uart_tx), .host(host)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc_now++;

    always @(negedge clk) begin
        if (host.rx_done) rxq.push_back(host.rx_data);
`ifdef UART_RX_FRAME_ERR_EN
        if (host.rx_frame_err) ferr_cnt++;
`endif
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] q_at(input int i);
        return (i < rxq.size()) ? 32'(rxq[i]) : 32'hDEAD;
    endfunction

    task automatic pulse_wr(input logic [7:0] d);
        host.tx_data = d; host.tx_wr = 1'b1;
        @(negedge clk);
        host.tx_wr = 1'b0;
    endtask

    task automatic wait_tx_done(input string tag);
        int c = 0;
        while (!host.tx_done && c < 800) begin @(negedge clk); c++; end
        if (!host.tx_done) chk(tag, 32'd0, 32'd1);
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop);
        drv = 1'b0; repeat (50) @(negedge clk);
        for (int i = 0; i < 8; i++) begin drv = b[i]; repeat (50) @(negedge clk); end
        drv = stop; repeat (50) @(negedge clk);
        drv = 1'b1; repeat (50) @(negedge clk);
    endtask

    initial begin
        int ticks, dbl, c, t0;
        logic prev;
        baudrate = 16'd10000; loop = 1'b1; drv = 1'b1;
        host.tx_wr = 1'b0; host.tx_data = 8'h00; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_enable_16", 32'(enable_16), 32'd0);
        chk("rst_uart_tx", 32'(uart_tx), 32'd1);
        chk("rst_tx_done", 32'(host.tx_done), 32'd0);
        chk("rst_rx_done", 32'(host.rx_done), 32'd0);
        chk("rst_rx_data", 32'(host.rx_data), 32'd0);
        rst_n = 1'b1;

        ticks = 0; dbl = 0; prev = 1'b0;
        repeat (5000) begin
            @(negedge clk);
            if (enable_16) begin ticks++; if (prev) dbl++; end
            prev = enable_16;
        end
        chk("tick_count_1600", 32'(ticks >= 1599 && ticks <= 1601), 32'd1);
        chk("tick_no_consecutive", 32'(dbl), 32'd0);

        rxq.delete();
        t0 = cyc_now;
        pulse_wr(8'hD5);
        c = 0;
        while (uart_tx && c < 8) begin @(negedge clk); c++; end
        chk("tx_start_low", 32'(c <= 3 && !uart_tx), 32'd1);
        wait_tx_done("tx_done_timeout_d5");
        chk("tx_done_latency", 32'((cyc_now - t0) >= 496 && (cyc_now - t0) <= 504), 32'd1);
        repeat (30) @(negedge clk);
        chk("rx_count_d5", 32'(rxq.size()), 32'd1);
        chk("rx_data_d5", q_at(0), 32'hD5);

        rxq.delete();
        pulse_wr(8'h01);
        repeat (100) @(negedge clk);
        pulse_wr(8'h77);
        wait_tx_done("tx_done_timeout_01");
        pulse_wr(8'h23);
        chk("b2b_start_low", 32'(uart_tx), 32'd0);
        wait_tx_done("tx_done_timeout_23");
        repeat (30) @(negedge clk);
        chk("b2b_rx_count", 32'(rxq.size()), 32'd2);
        chk("b2b_rx_first", q_at(0), 32'h01);
        chk("b2b_rx_second", q_at(1), 32'h23);

        rxq.delete();
        loop = 1'b0; drv = 1'b1;
        repeat (5) @(negedge clk);
        drv = 1'b0; repeat (3) @(negedge clk); drv = 1'b1;
        repeat (600) @(negedge clk);
        chk("glitch_no_rx", 32'(rxq.size()), 32'd0);
        drive_frame(8'h88, 1'b1);
        repeat (30) @(negedge clk);
        chk("post_glitch_count", 32'(rxq.size()), 32'd1);
        chk("post_glitch_data", q_at(0), 32'h88);

        rxq.delete(); ferr_cnt = 0;
        drive_frame(8'h55, 1'b0);
        repeat (30) @(negedge clk);
        chk("bad_stop_no_rx", 32'(rxq.size()), 32'd0);
        chk("bad_stop_rx_data_kept", 32'(host.rx_data), 32'h88);
`ifdef UART_RX_FRAME_ERR_EN
        chk("bad_stop_frame_err", 32'(ferr_cnt), 32'd1);
`endif

        loop = 1'b1; rxq.delete();
        pulse_wr(8'hAA);
        repeat (174) @(negedge clk);
        chk("pre_rst_tx_low", 32'(uart_tx), 32'd0);
        #5 rst_n = 1'b0;
        #1 chk("rst_async_uart_tx", 32'(uart_tx), 32'd1);
        @(negedge clk);
        chk("rst_mid_rx_data", 32'(host.rx_data), 32'd0);
        chk("rst_mid_tx_done", 32'(host.tx_done), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        rxq.delete();
        pulse_wr(8'h12);
        wait_tx_done("tx_done_timeout_12");
        repeat (30) @(negedge clk);
        chk("post_rst_rx_count", 32'(rxq.size()), 32'd1);
        chk("post_rst_rx_data", q_at(0), 32'h12);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_dds_transceiver.md
Name: uart_dds_transceiver

Overview:
- Self-contained 8N1 UART built around a fractional DDS baud-tick generator that produces a 16x-oversampling strobe.
- Serves as the host-link serial port between the external pins (ext_tx/ext_rx) and the s3g packet rx/tx logic.
- The same block also acts as the bench-side peer UART.
- Baud rate is a run-time input, given in units of 100 baud.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz; DDS modulus.
- BAUD_W, 16, width of the baudrate input.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- baudrate  input  BAUD_W  baud rate / 100 (e.g. 10000 = 1 Mbaud).
- enable_16  output  1  one-cycle strobe at 16 x baud.
- uart_rx  input  1  serial input, asynchronous to clk.
- uart_tx  output  1  serial output, idle high.
- tx_data  input  8  byte to transmit.
- tx_wr  input  1  one-cycle transmit request.
- tx_done  output  1  one-cycle pulse when the stop bit completes.
- rx_data  output  8  last correctly framed received byte.
- rx_done  output  1  one-cycle pulse when rx_data updates.

Behaviour:
- Reset values: enable_16=0, uart_tx=1, tx_done=0, rx_done=0, rx_data=0, DDS accumulator=0, both FSMs IDLE.
  - Reset mid-frame forces uart_tx=1 immediately and abandons both frames.
- DDS:
  - Each clk, acc_next = acc + baudrate*1600.
  - If acc_next >= CLK_FREQ: acc <= acc_next - CLK_FREQ and enable_16=1 next cycle; else acc <= acc_next and enable_16=0.
  - Accumulator width is clog2(2*CLK_FREQ); the product is computed at that width.
  - Legal range is baudrate*1600 < CLK_FREQ. Above that, enable_16 saturates to a one-per-cycle strobe with no further error bound.
  - baudrate=0 gives no ticks, and both FSMs freeze in place.
  - A baudrate change takes effect next cycle; the accumulator is not cleared.
- TX FSM, states IDLE, START, DATA, STOP:
  - In IDLE, tx_wr latches tx_data and enters START with uart_tx=0.
  - Each bit lasts 16 enable_16 ticks.
  - Data is sent LSB first: 8 bits, then a stop bit (1).
  - At the end of the stop bit: tx_done=1 for one cycle and return to IDLE.
  - tx_wr outside IDLE is ignored.
  - tx_wr in the same cycle as tx_done is accepted, so back-to-back frames have no idle gap.
  - The tick counter resets to 0 on start so the bit period is phase-aligned to accepted tx_wr (within one tick).
- RX:
  - Input passes a 2-flop synchronizer (ASYNC reset to 1).
  - FSM states IDLE, START, DATA, STOP.
  - IDLE: a synchronized 1->0 transition enters START with the tick count cleared.
  - START: at tick 8 (mid-bit) the line must still be 0, else return to IDLE (glitch rejection).
  - DATA: sample every 16 ticks thereafter, shifting LSB first, for 8 bits.
  - STOP: sample at mid stop bit.
    - If 1: rx_data <= shift register and rx_done=1 for one cycle.
    - If 0: byte discarded, rx_data unchanged.
  - Return to IDLE right after the stop sample, allowing resync on the next start edge.
  - rx_done latency is about 9.5 bit times after the start edge, plus 2 cycles of synchronizer delay.
- RX and TX are fully independent and full-duplex; simultaneous tx_done and rx_done are both legal.

Optional Feature:
- Macro UART_RX_FRAME_ERR_EN.
- When defined: adds output rx_frame_err (1 bit, reset 0). It pulses for one cycle whenever the stop-bit sample is 0; rx_data is unchanged and rx_done stays 0.
- When undefined: the port is absent and bad frames are silently dropped.

Decomposition:
- Package uart_pkg holds OVERSAMPLE=16, MID_TICK=8, DATA_BITS=8, and the TX/RX state enums.
- One sub-module, uart_baud_dds (DDS accumulator -> enable_16), instantiated once.
- TX and RX FSMs live in the top.

Test Plan (CLK_FREQ=50 MHz, baudrate=10000):
- Free-run 5000 cycles: exactly 1600 enable_16 pulses (+/-1), never two in consecutive cycles.
- Loopback uart_tx->uart_rx, tx_wr with 0xD5:
  - uart_tx low within 4 cycles.
  - tx_done after 500 +/-4 cycles.
  - rx_done once, with rx_data=0xD5.
- Send 0x01 then 0x23:
  - A second tx_wr during busy is ignored.
  - Re-issuing 0x23 on the tx_done cycle yields contiguous frames, and rx gets 0x01 then 0x23.
- 60 ns low glitch on uart_rx -> no rx_done; a following valid 0x88 frame is received correctly.
- Frame 0x55 with stop bit forced 0:
  - No rx_done, rx_data keeps its previous value.
  - With UART_RX_FRAME_ERR_EN, one rx_frame_err pulse.
- Assert rst_n=0 mid-TX-byte -> uart_tx=1 asynchronously; after release, tx_wr 0x12 transmits a clean frame.
